// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI sample path (receiver and transmitter).
//   SPI_WORD_W     : bits per SPI word, common to both directions
//   spi_rx_state_t : receiver FSM states
//   sat_inc16      : saturating +1 on a 16-bit counter
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_WORD_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
// Synchronous show-ahead FIFO. The head entry is presented on dout whenever
// the FIFO is non-empty; dout reads as zero when empty.
//
// Parameters:
//   WIDTH : word width
//   DEPTH : number of entries, power of 2, >= 2
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data; ignored when full unless a pop
//                  happens in the same cycle
//   pop          : remove the head entry; ignored when empty
//   full, empty  : occupancy flags
//   dout         : head entry
//
// Handshake: a push and a pop in the same cycle on a full FIFO both take
// effect. On an empty FIFO only the push takes effect, because there is no
// head entry to remove.
// -----------------------------------------------------------------------------
module spi_rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  // One extra bit so that DEPTH entries and zero entries are distinct.
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_rx.sv
// -----------------------------------------------------------------------------
// spi_rx
// SPI peripheral receiver, mode 0 (CPOL=0, CPHA=0), MSB first. sck, cs_n and
// sdi are oversampled in the clk domain (clk >= 4x sck). Received words are
// buffered in a show-ahead FIFO drained over a valid/ready handshake.
//
// Parameters:
//   WORD_W      : bits per word (default SPI_WORD_W = 16)
//   FIFO_DEPTH  : word buffer entries, power of 2, >= 2
//   SYNC_STAGES : flip-flops per input synchronizer, >= 2
//
// Ports:
//   clk, reset_n      : system clock, asynchronous active-low reset
//   sck, cs_n, sdi    : SPI bus from the MCU, asynchronous to clk
//   rx_data, rx_valid : FIFO head word and non-empty flag
//   rx_ready          : consumer accepts rx_data
//   busy              : frame in progress; mirrors the FSM state (1 = SHIFT)
//   overflow          : sticky, a word was dropped on a full FIFO
//   frame_err         : sticky, cs_n rose with a partial word
//   clr_err           : synchronous clear of both sticky flags; a set event
//                       in the same cycle wins
//   word_cnt, drop_cnt: (SPI_RX_STATS_EN only) saturating counts of words
//                       pushed / dropped; not affected by clr_err
//
// Handshake: rx_data is transferred on every clk edge where rx_valid and
// rx_ready are both high; rx_valid never depends on rx_ready.
//
// Compile-time option: define SPI_RX_STATS_EN to add word_cnt / drop_cnt.
//
// Latency: the FIFO write happens SYNC_STAGES+2 edges after the edge that
// first samples the final sck high (synchronizer, shift, push stage, write).
// -----------------------------------------------------------------------------
module spi_rx
  import spi_pkg::*;
#(
  parameter int WORD_W      = SPI_WORD_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              sdi,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clr_err
`ifdef SPI_RX_STATS_EN
  ,
  output logic [15:0]       word_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int CNT_W = $clog2(WORD_W);

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   cs_s;
  logic                   sdi_s;
  logic                   sck_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  // The cs_n chain resets low on purpose: if reset is released while the MCU
  // already holds cs_n low, no falling edge is seen and that frame is not
  // joined. An idle-high cs_n only produces a rising edge, ignored in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync <= '0;
      cs_sync  <= '0;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sck_d    <= sck_s;
      cs_d     <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // ---------------------------------------------------------------------------
  // Deserializer FSM
  // ---------------------------------------------------------------------------
  spi_rx_state_t     state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic              word_vld;   // one-cycle pulse: shift_reg holds a full word
  logic              ferr_evt;   // one-cycle pulse: frame ended mid-word

  logic              shift_now;
  logic              last_bit;
  logic [WORD_W-1:0] shift_next;
  logic [CNT_W-1:0]  cnt_next;

  always_comb begin
    shift_now  = (state == SHIFT) && sck_rise;
    last_bit   = (bit_cnt == CNT_W'(WORD_W - 1));
    shift_next = {shift_reg[WORD_W-2:0], sdi_s};
    cnt_next   = bit_cnt;
    if (shift_now) cnt_next = last_bit ? '0 : bit_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      busy      <= 1'b0;
      word_vld  <= 1'b0;
      ferr_evt  <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      ferr_evt <= 1'b0;
      case (state)
        IDLE: begin
          // sck activity outside a frame is ignored.
          if (cs_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (shift_now) shift_reg <= shift_next;
          word_vld <= shift_now && last_bit;
          bit_cnt  <= cnt_next;
          // A bit arriving with the cs_n rise is shifted first; the end-of-
          // frame check then looks at the updated count.
          if (cs_rise) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            ferr_evt <= (cnt_next != '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Push stage: copies the completed word out of shift_reg, which stays
  // stable for several clk cycles because sck runs at most at clk/4.
  // ---------------------------------------------------------------------------
  logic              push_vld;
  logic [WORD_W-1:0] push_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_vld  <= 1'b0;
      push_word <= '0;
    end else begin
      push_vld <= word_vld;
      if (word_vld) push_word <= shift_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic drop;

  assign rx_valid = ~fifo_empty;
  assign pop      = rx_valid && rx_ready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign drop     = push_vld && fifo_full && !pop;

  spi_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_vld),
    .din     (push_word),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dout    (rx_data)
  );

  // ---------------------------------------------------------------------------
  // Sticky error flags: set has priority over clr_err.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (ferr_evt)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

`ifdef SPI_RX_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters, saturating at 16'hFFFF.
  // ---------------------------------------------------------------------------
  logic accepted;

  assign accepted = push_vld && !drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (accepted) word_cnt <= sat_inc16(word_cnt);
      if (drop)     drop_cnt <= sat_inc16(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_rx
// Directed bench for spi_rx: a vector table of single frames plus hand-written
// sequences for latency, back-to-back words, overflow, full-with-pop and
// reset in the middle of a frame. SPI inputs change on negedges; rx_ready and
// clr_err change 1 time unit after a posedge; outputs are sampled on negedges.
// -----------------------------------------------------------------------------
module tb_spi_rx;

  localparam int W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic         clk      = 1'b0;
  logic         reset_n  = 1'b0;
  logic         sck      = 1'b0;
  logic         cs_n     = 1'b1;
  logic         sdi      = 1'b0;
  logic         rx_ready = 1'b0;
  logic         clr_err  = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         overflow;
  logic         frame_err;
`ifdef SPI_RX_STATS_EN
  logic [15:0]  word_cnt;
  logic [15:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  spi_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sck       (sck),
    .cs_n      (cs_n),
    .sdi       (sdi),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
`ifdef SPI_RX_STATS_EN
    ,
    .word_cnt  (word_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Every handshake seen on a negedge becomes a pop at the next posedge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got=%0h want=none", rx_data);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", rx_data, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic spi_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_fall_t();
    @(negedge clk);
    cs_n = 1'b0;
    spi_wait(4);
  endtask

  task automatic cs_rise_t();
    spi_wait(4);
    cs_n = 1'b1;
    spi_wait(8);
  endtask

  // sck runs at clk/8; sdi is set up four clk cycles before each rise.
  task automatic send_bit(input logic b);
    sdi = b;
    spi_wait(4);
    sck = 1'b1;
    spi_wait(4);
    sck = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input int nbits);
    cs_fall_t();
    for (int i = 0; i < nbits; i++) begin
      if (i < W) send_bit(w[W-1-i]);
      else       send_bit(1'b0);
    end
    cs_rise_t();
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    set_ready(1'b1);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_valid"}, rx_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    cs_n     = 1'b1;
    sck      = 1'b0;
    sdi      = 1'b0;
    clr_err  = 1'b0;
    rx_ready = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    spi_wait(6);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] word;
    int           nbits;
    logic         exp_push;
    logic         exp_ferr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] fill[4];
    logic [W-1:0] five[5];

    vecs[0] = '{16'hA5C3, 16, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, 16, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16, 1'b1, 1'b0};
    vecs[3] = '{16'h8001, 16, 1'b1, 1'b0};
    vecs[4] = '{16'hA5C3,  7, 1'b0, 1'b1};
    vecs[5] = '{16'h00FF, 16, 1'b1, 1'b0};
    vecs[6] = '{16'h0000,  0, 1'b0, 1'b0};
    vecs[7] = '{16'h6B2D, 17, 1'b1, 1'b1};
    vecs[8] = '{16'hFFFF, 15, 0, 1'b1};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_rx_data", rx_data, 16'h0000);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    spi_wait(6);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_valid", rx_valid, 1'b0);

    // ---- latency: rx_valid after SYNC_STAGES+2 = 4 edges ----
    w = 16'h3C5A;
    cs_fall_t();
    check("lat_busy", busy, 1'b1);
    for (int i = 0; i < W - 1; i++) send_bit(w[W-1-i]);
    sdi = w[0];
    spi_wait(4);
    sck = 1'b1;
    exp_q.push_back(w);
    repeat (4) @(negedge clk);
    check("lat_early", rx_valid, 1'b0);
    @(negedge clk);
    check("lat_on_time", rx_valid, 1'b1);
    check("lat_data", rx_data, w);
    spi_wait(3);
    sck = 1'b0;
    cs_rise_t();
    check("lat_busy_end", busy, 1'b0);
    wait_drain("lat");

    // ---- table of single frames, rx_ready held high ----
    for (int k = 0; k < 9; k++) begin
      pulse_clr();
      if (vecs[k].exp_push) exp_q.push_back(vecs[k].word);
      send_frame(vecs[k].word, vecs[k].nbits);
      wait_drain($sformatf("vec%0d", k));
      check($sformatf("vec%0d_frame_err", k), frame_err, vecs[k].exp_ferr);
      check($sformatf("vec%0d_overflow", k), overflow, 1'b0);
      check($sformatf("vec%0d_busy", k), busy, 1'b0);
    end

    // ---- frame abort, sticky flag, recovery, clr_err ----
    pulse_clr();
    check("abort_pre_clr", frame_err, 1'b0);
    send_frame(16'hA5C3, 7);
    check("abort_ferr", frame_err, 1'b1);
    check("abort_no_push", rx_valid, 1'b0);
    exp_q.push_back(16'h00FF);
    send_frame(16'h00FF, 16);
    wait_drain("abort_next");
    check("abort_sticky", frame_err, 1'b1);
    pulse_clr();
    check("abort_cleared", frame_err, 1'b0);

    // ---- back-to-back words in one frame, rx_ready low ----
    set_ready(1'b0);
    w = 16'h1234;
    cs_fall_t();
    for (int i = 0; i < W; i++) send_bit(w[W-1-i]);
    w = 16'hBEEF;
    for (int i = 0; i < W; i++) send_bit(w[W-1-i]);
    cs_rise_t();
    check("b2b_valid", rx_valid, 1'b1);
    check("b2b_head", rx_data, 16'h1234);
    check("b2b_ferr", frame_err, 1'b0);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hBEEF);
    wait_drain("b2b");

    // ---- overflow: five words into a 4-deep FIFO ----
    do_reset();
    five[0] = 16'h1111; five[1] = 16'h2222; five[2] = 16'h3333;
    five[3] = 16'h4444; five[4] = 16'h9999;
    cs_fall_t();
    for (int k = 0; k < 5; k++) begin
      w = five[k];
      for (int i = 0; i < W; i++) send_bit(w[W-1-i]);
    end
    cs_rise_t();
    check("ovf_flag", overflow, 1'b1);
    check("ovf_ferr", frame_err, 1'b0);
    check("ovf_head", rx_data, 16'h1111);
`ifdef SPI_RX_STATS_EN
    check("ovf_word_cnt", word_cnt, 16'd4);
    check("ovf_drop_cnt", drop_cnt, 16'd1);
`endif
    for (int k = 0; k < 4; k++) exp_q.push_back(five[k]);
    wait_drain("ovf");
    check("ovf_sticky", overflow, 1'b1);
    pulse_clr();
    check("ovf_cleared", overflow, 1'b0);

    // ---- full FIFO, pop in the same cycle as the push ----
    set_ready(1'b0);
    fill[0] = 16'hA001; fill[1] = 16'hA002; fill[2] = 16'hA003; fill[3] = 16'hA004;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(fill[k]);
      send_frame(fill[k], 16);
    end
    check("full_valid", rx_valid, 1'b1);
    w = 16'h5555;
    cs_fall_t();
    for (int i = 0; i < W - 1; i++) send_bit(w[W-1-i]);
    sdi = w[0];
    spi_wait(4);
    sck = 1'b1;
    exp_q.push_back(w);
    repeat (4) @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("fullpop_overflow", overflow, 1'b0);
    check("fullpop_valid", rx_valid, 1'b1);
    check("fullpop_head", rx_data, fill[1]);
    spi_wait(3);
    sck = 1'b0;
    cs_rise_t();
    check("fullpop_overflow_end", overflow, 1'b0);
    wait_drain("fullpop");
`ifdef SPI_RX_STATS_EN
    check("fullpop_word_cnt", word_cnt, 16'd9);
    check("fullpop_drop_cnt", drop_cnt, 16'd1);
`endif

    // ---- reset in the middle of a frame ----
    set_ready(1'b0);
    send_frame(16'hFFFF, 7);
    exp_q.push_back(16'h1357);
    send_frame(16'h1357, 16);
    check("rmf_pre_valid", rx_valid, 1'b1);
    check("rmf_pre_ferr", frame_err, 1'b1);
    w = 16'h9ABC;
    cs_fall_t();
    for (int i = 0; i < 9; i++) send_bit(w[W-1-i]);
    check("rmf_pre_busy", busy, 1'b1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rmf_rx_valid", rx_valid, 1'b0);
    check("rmf_rx_data", rx_data, 16'h0000);
    check("rmf_busy", busy, 1'b0);
    check("rmf_frame_err", frame_err, 1'b0);
    check("rmf_overflow", overflow, 1'b0);
    spi_wait(2);
    reset_n = 1'b1;
    for (int i = 9; i < W; i++) send_bit(w[W-1-i]);
    check("rmf_tail_busy", busy, 1'b0);
    cs_rise_t();
    check("rmf_tail_ferr", frame_err, 1'b0);
    check("rmf_tail_valid", rx_valid, 1'b0);
    set_ready(1'b1);
    exp_q.push_back(16'hCAFE);
    send_frame(16'hCAFE, 16);
    wait_drain("rmf_next");
    check("rmf_next_ferr", frame_err, 1'b0);
`ifdef SPI_RX_STATS_EN
    check("rmf_word_cnt", word_cnt, 16'd1);
    check("rmf_drop_cnt", drop_cnt, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI peripheral receiver, mode 0 (CPOL=0, CPHA=0), MSB first. The MCU drives sck, cs_n and sdi toward the FPGA; this is the return path to the existing sample transmitter.
- sck, cs_n and sdi are oversampled in the clk domain. Words are deserialized and buffered in a small FIFO that downstream audio logic drains over a valid/ready handshake.
- The block is used for processed or mixed samples and control words coming back from the MCU.

Parameters:
- WORD_W, 16, bits per word.
- FIFO_DEPTH, 4, word buffer entries; must be a power of 2, ≥2.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; ≥2.

Ports:
- clk  in  1  system clock; frequency ≥ 4× sck frequency.
- reset_n  in  1  reset.
- sck  in  1  SPI clock from MCU, asynchronous to clk.
- cs_n  in  1  chip select from MCU, active-low, asynchronous.
- sdi  in  1  serial data from MCU, asynchronous.
- rx_data  out  WORD_W  FIFO head word (show-ahead).
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts rx_data.
- busy  out  1  frame in progress (state SHIFT).
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- frame_err  out  1  sticky: cs_n rose with a partial word.
- clr_err  in  1  synchronous clear of overflow and frame_err.

Interface decision: clock clk; reset reset_n, asynchronous, active-low.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, busy=0, overflow=0, frame_err=0.
  - FIFO empty, bit counter 0, state IDLE.
- Input capture:
  - sck, cs_n and sdi each pass through a SYNC_STAGES-deep synchronizer.
  - One extra register per signal gives the previous value, for edge detection.
  - sck_rise = synced high and previous low. sdi is sampled from its synchronized copy in the same cycle.
- State IDLE:
  - Synced cs_n falling → SHIFT, bit counter cleared.
  - sck edges are ignored while in IDLE.
- State SHIFT:
  - On each sck_rise: shift_reg = {shift_reg[WORD_W-2:0], sdi_s} and bit counter +1.
  - When the WORD_W-th bit is shifted: the assembled word is pushed to the FIFO and the counter wraps to 0.
  - Continuous words within one cs_n frame are allowed.
- Leaving SHIFT:
  - Synced cs_n rising with counter 0 → IDLE, no error.
  - Synced cs_n rising with counter ≠ 0 → partial word discarded, frame_err set, counter cleared, → IDLE.
- sck_rise and cs_n rise in the same cycle: the bit is shifted first, then the cs_n rule is evaluated on the updated counter.
- Latency: rx_valid rises exactly SYNC_STAGES+2 clk edges after the first clk edge that samples the final sck high. This applies when the FIFO was empty and no pop is occurring.
- FIFO:
  - Pop occurs when rx_valid && rx_ready.
  - Push when full and no pop in the same cycle: the new word is dropped and overflow is set.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push and pop in the same cycle when empty: push only; rx_valid=0 that cycle.
  - Pointers wrap modulo FIFO_DEPTH. A count register of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- Sticky flags: clr_err clears overflow and frame_err. A set event in the same cycle as clr_err wins.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the FSM waits for a fresh cs_n fall; a frame already in progress is not joined.

Optional Feature:
- Macro SPI_RX_STATS_EN.
- When defined, two extra output ports are compiled in:
  - word_cnt, 16 bits: counts every word pushed into the FIFO.
  - drop_cnt, 16 bits: counts every word dropped on overflow.
  - Both counters saturate at 16'hFFFF, reset to 0, and are unaffected by clr_err.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package spi_pkg holds:
  - localparam SPI_WORD_W=16, shared with the transmitter;
  - the enum spi_rx_state_t {IDLE, SHIFT}.
- Sub-module spi_rx_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH, plus push, pop, full, empty, dout. It is also reusable by the transmitter.

Test Plan:
1. Single word: one cs_n frame sends 16'hA5C3, rx_ready=1 → one rx_valid pulse with rx_data=16'hA5C3, frame_err=0, overflow=0, busy=0 after cs_n rises.
2. Back-to-back words: one cs_n frame carries 16'h1234 and 16'hBEEF, rx_ready=0 → FIFO holds both, in order, after a later drain with rx_ready=1.
3. Overflow: five words with rx_ready=0 and FIFO_DEPTH=4 → words 1–4 retained, the fifth dropped, overflow=1. With SPI_RX_STATS_EN: word_cnt=4, drop_cnt=1.
4. Frame abort: cs_n rises after 7 bits → frame_err=1 and no FIFO push. A following full frame with 16'h00FF is received correctly. Pulsing clr_err clears frame_err.
5. Full with simultaneous pop: FIFO full, rx_ready=1 held while a new word 16'h5555 completes → no overflow, count stays 4, 16'h5555 is last out.
6. Reset mid-frame: reset_n pulsed low after 9 bits → all outputs 0. The remaining bits of that frame are ignored. The next frame with 16'hCAFE is received correctly.
